// File: rtl/banyan_trig_pkg.sv
// rtl/banyan_trig_pkg.sv - shared state encoding and limits for the banyan trigger sequencer
package banyan_trig_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } trig_state_t;

  localparam logic [7:0] MISS_MAX = 8'd255;

endpackage

// File: rtl/trig_edge_detect.sv
// rtl/trig_edge_detect.sv - selectable rising/falling edge detector for the external trigger
module trig_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic edge_sel,
  output logic hit
);

  logic ext_d;

  // ext_d clears to 0, so a level already high at reset release reads as a rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext_d <= 1'b0;
    else     ext_d <= din;
  end

  assign hit = edge_sel ? (~din & ext_d) : (din & ~ext_d);

endmodule

// File: rtl/banyan_trig_ctl.sv
// rtl/banyan_trig_ctl.sv - acquisition trigger sequencer driving banyan_mem reset/run
// Optional fill-start timestamp enabled by BANYAN_TRIG_TS_EN.
module banyan_trig_ctl
  import banyan_trig_pkg::*;
#(
  parameter int dw  = 16,
  parameter int cw  = 16,
  parameter int tsw = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic           force_trig,
  input  logic           disarm,
  input  logic           ext_trig,
  input  logic           edge_sel,
  input  logic [dw-1:0]  trig_delay,
  input  logic           auto_rearm,
  input  logic           rollover,
  output logic           buf_reset,
  output logic           buf_run,
  output logic [2:0]     state,
  output logic [cw-1:0]  trig_count,
  output logic [7:0]     missed_count,
  output logic [tsw-1:0] trig_ts
);

  trig_state_t   cur, nxt;
  logic [dw-1:0] dcnt, dcnt_nxt;
  logic          hit, fill_start, missed;

  trig_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .din      (ext_trig),
    .edge_sel (edge_sel),
    .hit      (hit)
  );

  always_comb begin
    nxt        = cur;
    dcnt_nxt   = dcnt;
    fill_start = 1'b0;
    if (disarm) begin
      nxt = IDLE;
    end else if (force_trig) begin
      nxt        = FILL;
      fill_start = 1'b1;
    end else begin
      case (cur)
        IDLE:  if (arm) nxt = ARMED;
        ARMED: begin
          if (hit) begin
            if (trig_delay == '0) begin
              nxt        = FILL;
              fill_start = 1'b1;
            end else begin
              nxt      = DELAY;
              dcnt_nxt = trig_delay - 1'b1;
            end
          end
        end
        DELAY: begin
          if (dcnt == '0) begin
            nxt        = FILL;
            fill_start = 1'b1;
          end else begin
            dcnt_nxt = dcnt - 1'b1;
          end
        end
        FILL:    if (rollover) nxt = DONE;
        DONE:    if (auto_rearm || arm) nxt = ARMED;
        default: nxt = IDLE;
      endcase
    end
  end

  // Only ARMED consumes an edge; every other state counts it as missed
  assign missed = hit && (cur != ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= IDLE;
      dcnt         <= '0;
      buf_reset    <= 1'b0;
      buf_run      <= 1'b0;
      trig_count   <= '0;
      missed_count <= '0;
    end else begin
      cur       <= nxt;
      dcnt      <= dcnt_nxt;
      buf_reset <= fill_start;
      buf_run   <= (cur == FILL);
      if (fill_start) trig_count <= trig_count + 1'b1;
      if (missed && (missed_count != MISS_MAX)) missed_count <= missed_count + 8'd1;
    end
  end

  assign state = cur;

`ifdef BANYAN_TRIG_TS_EN
  logic [tsw-1:0] ts_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (fill_start) trig_ts <= ts_cnt;
    end
  end
`else
  assign trig_ts = '0;
`endif

endmodule

// File: tb/tb_banyan_trig_ctl.sv
// tb/tb_banyan_trig_ctl.sv - directed and random checks of banyan_trig_ctl against a cycle model
module tb_banyan_trig_ctl;

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_DELAY = 2;
  localparam int S_FILL  = 3;
  localparam int S_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, force_trig = 1'b0, disarm = 1'b0;
  logic        ext_trig = 1'b0, edge_sel = 1'b0;
  logic [15:0] trig_delay = '0;
  logic        auto_rearm = 1'b0, rollover = 1'b0;
  logic        buf_reset, buf_run;
  logic [2:0]  state;
  logic [15:0] trig_count;
  logic [7:0]  missed_count;
  logic [31:0] trig_ts;

  int n_checks = 0;
  int n_errors = 0;

  // model state: what the DUT registers must hold after the next edge
  int          m_state;
  logic        m_ext_d;
  logic [15:0] m_trig;
  int          m_miss;
  logic [31:0] m_ts, m_trig_ts;
  logic        m_exp_reset, m_exp_run;
  int          m_cyc = 0;
  int          m_fire_at = 0;

  banyan_trig_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .force_trig   (force_trig),
    .disarm       (disarm),
    .ext_trig     (ext_trig),
    .edge_sel     (edge_sel),
    .trig_delay   (trig_delay),
    .auto_rearm   (auto_rearm),
    .rollover     (rollover),
    .buf_reset    (buf_reset),
    .buf_run      (buf_run),
    .state        (state),
    .trig_count   (trig_count),
    .missed_count (missed_count),
    .trig_ts      (trig_ts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state     = S_IDLE;
    m_ext_d     = 1'b0;
    m_trig      = '0;
    m_miss      = 0;
    m_ts        = '0;
    m_trig_ts   = '0;
    m_exp_reset = 1'b0;
    m_exp_run   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("state", 32'(state), 32'(m_state));
    chk("buf_reset", 32'(buf_reset), 32'(m_exp_reset));
    chk("buf_run", 32'(buf_run), 32'(m_exp_run));
    chk("trig_count", 32'(trig_count), 32'(m_trig));
    chk("missed_count", 32'(missed_count), 32'(m_miss));
`ifdef BANYAN_TRIG_TS_EN
    chk("trig_ts", trig_ts, m_trig_ts);
`else
    chk("trig_ts", trig_ts, 32'd0);
`endif
  endtask

  // One clock: drive inputs, advance the model by the rules, sample after the edge
  task automatic step(input logic a, input logic f, input logic d, input logic e,
                      input logic es, input logic [15:0] td, input logic ar, input logic ro);
    logic hit, start;
    int   nst;
    arm = a; force_trig = f; disarm = d; ext_trig = e;
    edge_sel = es; trig_delay = td; auto_rearm = ar; rollover = ro;
    hit   = es ? (!e && m_ext_d) : (e && !m_ext_d);
    start = 1'b0;
    nst   = m_state;
    if (d) nst = S_IDLE;
    else if (f) begin nst = S_FILL; start = 1'b1; end
    else if (m_state == S_IDLE && a) nst = S_ARMED;
    else if (m_state == S_ARMED && hit) begin
      if (td == 0) begin nst = S_FILL; start = 1'b1; end
      else begin nst = S_DELAY; m_fire_at = m_cyc + int'(td); end
    end
    else if (m_state == S_DELAY && m_cyc == m_fire_at) begin nst = S_FILL; start = 1'b1; end
    else if (m_state == S_FILL && ro) nst = S_DONE;
    else if (m_state == S_DONE && (ar || a)) nst = S_ARMED;
    m_exp_reset = start;
    m_exp_run   = (m_state == S_FILL);
    if (start) begin m_trig = m_trig + 16'd1; m_trig_ts = m_ts; end
    if (hit && m_state != S_ARMED && m_miss < 255) m_miss++;
    m_ext_d = e;
    m_state = nst;
    m_ts    = m_ts + 32'd1;
    m_cyc++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic e, input logic [15:0] td);
    step(1'b0, 1'b0, 1'b0, e, 1'b0, td, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [15:0] cnt_before;
  logic        r_ext, r_es, r_ar;
  logic [15:0] r_td;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // delay 0: buf_reset one cycle after decision, buf_run one cycle later
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    repeat (3) idle(1'b0, 16'd0);
    idle(1'b1, 16'd0);
    chk("t1_buf_reset", 32'(buf_reset), 32'd1);
    chk("t1_run_low", 32'(buf_run), 32'd0);
    chk("t1_count", 32'(trig_count), 32'd1);
    idle(1'b1, 16'd0);
    chk("t1_run_high", 32'(buf_run), 32'd1);
    chk("t1_reset_gone", 32'(buf_reset), 32'd0);

    // delay 5: five DELAY cycles then the fill
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    idle(1'b0, 16'd5);
    cnt_before = trig_count;
    idle(1'b1, 16'd5);
    chk("t2_delay0", 32'(state), S_DELAY);
    for (int i = 1; i < 5; i++) begin
      idle(1'b1, 16'd9);
      chk("t2_delay", 32'(state), S_DELAY);
    end
    idle(1'b1, 16'd9);
    chk("t2_fill", 32'(state), S_FILL);
    chk("t2_buf_reset", 32'(buf_reset), 32'd1);
    repeat (3) idle(1'b1, 16'd0);
    chk("t2_count", 32'(trig_count), 32'(cnt_before + 16'd1));

    // force beats rollover while filling
    cnt_before = trig_count;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    chk("t3_state", 32'(state), S_FILL);
    chk("t3_buf_reset", 32'(buf_reset), 32'd1);
    chk("t3_count", 32'(trig_count), 32'(cnt_before + 16'd1));

    // disarm mid-delay with three cycles remaining, then disarm+force
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    idle(1'b0, 16'd6);
    idle(1'b1, 16'd6);
    idle(1'b1, 16'd6);
    idle(1'b1, 16'd6);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd6, 1'b0, 1'b0);
    chk("t5_idle", 32'(state), S_IDLE);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1, 16'd6);
      chk("t5_no_reset", 32'(buf_reset), 32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("t5_df_idle", 32'(state), S_IDLE);
    idle(1'b1, 16'd0);
    chk("t5_df_no_reset", 32'(buf_reset), 32'd0);

    // auto re-arm: three clean fills, nothing missed
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
      chk("t4_rearmed", 32'(state), S_ARMED);
    end
    chk("t4_count", 32'(trig_count), 32'd3);
    chk("t4_missed", 32'(missed_count), 32'd0);

    // 300 edges during a fill saturate the miss counter
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) idle(i[0] == 1'b0, 16'd0);
    chk("t4_missed_sat", 32'(missed_count), 32'd255);

    // async reset in the middle of a fill
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    repeat (3) idle(1'b0, 16'd0);
    chk("t6_running", 32'(buf_run), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_run_drop", 32'(buf_run), 32'd0);
    chk("t6_state", 32'(state), S_IDLE);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef BANYAN_TRIG_TS_EN
    do_reset();
    repeat (1000) idle(1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("ts_1000", trig_ts, 32'd1000);
`endif

    // random traffic against the model
    do_reset();
    r_ext = 1'b0; r_es = 1'b0; r_ar = 1'b0; r_td = '0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        r_td = 16'($urandom_range(0, 5));
        r_ar = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) r_ext = ~r_ext;
      if ($urandom_range(0, 80) == 0) r_es = ~r_es;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, r_ext, r_es, r_td, r_ar,
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
